// File: rtl/aqed_pkg.sv
// Shared types and helpers for the A-QED output monitor.
// Holds the monitor state encoding and the index-pair legality rule.
package aqed_pkg;

    localparam int AQED_DATA_W = 16;
    localparam int AQED_CNT_W  = 16;

    typedef enum logic [1:0] {
        MON_IDLE,
        MON_COLLECT,
        MON_DONE
    } mon_state_t;

    function automatic logic idx_pair_ok(
        input logic [AQED_CNT_W-1:0] orig,
        input logic [AQED_CNT_W-1:0] dup,
        input logic [AQED_CNT_W-1:0] depth
    );
        return (depth != '0) && (orig < dup) && (dup < depth);
    endfunction

endpackage

// File: rtl/aqed_out_monitor_if.sv
// Accelerator output stream handshake (data_out / valid_out / ren_in).
// master = memory_core side, slave = monitor side.
interface aqed_out_monitor_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] acc_data;
    logic              acc_valid;
    logic              acc_rdy;

    modport master (
        output acc_data,
        output acc_valid,
        input  acc_rdy
    );

    modport slave (
        input  acc_data,
        input  acc_valid,
        output acc_rdy
    );
endinterface

// File: rtl/aqed_wrap_counter.sv
// Beat counter inside a tile; returns to 0 after limit-1.
// wrap is combinational: high on the increment that rolls over.
module aqed_wrap_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clk_en,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = inc && (count == limit - W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clk_en && inc) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/aqed_out_monitor.sv
// A-QED receive-side checker: captures original/duplicate beats, compares.
// Optional stall watchdog enabled by defining AQED_OUT_MON_TIMEOUT_EN.
module aqed_out_monitor
    import aqed_pkg::*;
#(
    parameter int DATA_W      = AQED_DATA_W,
    parameter int CNT_W       = AQED_CNT_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic [CNT_W-1:0] depth,
    input  logic             idx_valid,
    input  logic [CNT_W-1:0] orig_idx,
    input  logic [CNT_W-1:0] dup_idx,
    aqed_out_monitor_if.slave acc,
    output logic [CNT_W-1:0] seq_pointer,
    output logic             qed_done,
    output logic             qed_check,
    output logic             idx_err,
    output logic             timeout
);

    mon_state_t state_q, state_d;

    logic [CNT_W-1:0]  orig_iq, dup_iq;
    logic [CNT_W-1:0]  beat_cnt, tile_cnt;
    logic [DATA_W-1:0] orig_q;
    logic              orig_f, dup_f;
    logic              rdy_q;
    logic              wrap, accept, first_tile;
    logic              idx_go, idx_ok;
    logic              orig_hit, dup_hit, wd_hit;
    logic              rdy_d, check_d, err_d;

    assign acc.acc_rdy = rdy_q;

    assign accept = clk_en && acc.acc_valid && rdy_q
                 && (state_q == MON_COLLECT);
    assign first_tile = (tile_cnt == '0);
    assign orig_hit = accept && first_tile && (beat_cnt == orig_iq);
    assign dup_hit  = accept && first_tile && (beat_cnt == dup_iq);

    assign idx_go = clk_en && idx_valid && (state_q == MON_IDLE);
    assign idx_ok = idx_pair_ok(orig_idx, dup_idx, depth);

    aqed_wrap_counter #(.W(CNT_W)) u_beat (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .inc    (accept),
        .limit  (depth),
        .count  (beat_cnt),
        .wrap   (wrap)
    );

`ifdef AQED_OUT_MON_TIMEOUT_EN
    logic [CNT_W-1:0] wd_cnt;
    logic             timeout_q;
    logic             stall;

    assign stall  = (state_q == MON_COLLECT) && rdy_q && !accept;
    assign wd_hit = clk_en && stall
                 && (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign timeout = timeout_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else if (clk_en) begin
            if (accept) begin
                wd_cnt <= '0;
            end else if (stall) begin
                wd_cnt <= wd_cnt + CNT_W'(1);
            end
            if (wd_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign qed_done = dup_f || idx_err || timeout_q;
`else
    assign wd_hit   = 1'b0;
    assign timeout  = 1'b0;
    assign qed_done = dup_f || idx_err;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MON_IDLE;
        end else if (clk_en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MON_IDLE: begin
                if (idx_go) begin
                    state_d = idx_ok ? MON_COLLECT : MON_DONE;
                end
            end
            MON_COLLECT: begin
                if (dup_hit || wd_hit) begin
                    state_d = MON_DONE;
                end
            end
            default: state_d = state_q;
        endcase
    end

    // ren drops for one cycle after the last beat of a tile
    always_comb begin
        rdy_d   = (state_d == MON_COLLECT) && !wrap;
        check_d = qed_check;
        err_d   = idx_err;
        unique case (1'b1)
            idx_go && !idx_ok: begin
                check_d = 1'b1;
                err_d   = 1'b1;
            end
            dup_hit: begin
                check_d = orig_f && (orig_q == acc.acc_data);
            end
            wd_hit: begin
                check_d = 1'b0;
            end
            default: ;
        endcase
    end

    // the dup beat is compared on the fly, so only its flag is kept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_q       <= 1'b0;
            qed_check   <= 1'b0;
            idx_err     <= 1'b0;
            seq_pointer <= '0;
            tile_cnt    <= '0;
            orig_iq     <= '0;
            dup_iq      <= '0;
            orig_q      <= '0;
            orig_f      <= 1'b0;
            dup_f       <= 1'b0;
        end else if (clk_en) begin
            rdy_q     <= rdy_d;
            qed_check <= check_d;
            idx_err   <= err_d;
            if (idx_go) begin
                orig_iq <= orig_idx;
                dup_iq  <= dup_idx;
            end
            if (accept && (seq_pointer != '1)) begin
                seq_pointer <= seq_pointer + CNT_W'(1);
            end
            if (wrap && (tile_cnt != '1)) begin
                tile_cnt <= tile_cnt + CNT_W'(1);
            end
            if (orig_hit) begin
                orig_q <= acc.acc_data;
                orig_f <= 1'b1;
            end
            if (dup_hit) begin
                dup_f <= 1'b1;
            end
        end
    end

endmodule
